// File: rtl/io_bus_bridge_reg.sv
// Registered MCS IO-bus to system-bus bridge: decodes the MMIO window, issues one
// single-cycle sys_rd/sys_wr per IO strobe, waits a fixed read latency, and answers misses locally.
module io_bus_bridge_reg #(
    parameter logic [31:0] BRIDGE_BASE = 32'hc000_0000,
    parameter int unsigned RD_LATENCY  = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        io_addr_strobe,
    input  logic        io_read_strobe,
    input  logic        io_write_strobe,
    input  logic [3:0]  io_byte_enable,
    input  logic [31:0] io_address,
    input  logic [31:0] io_write_data,
    output logic [31:0] io_read_data,
    output logic        io_ready,
    output logic        sys_mmio_cs,
    output logic        sys_wr,
    output logic        sys_rd,
    output logic [20:0] sys_addr,
    output logic [31:0] sys_wr_data,
    output logic [3:0]  sys_be,
    input  logic [31:0] sys_rd_data,
    output logic [7:0]  miss_count
);

    localparam int unsigned AW = 21;
    localparam int unsigned DW = 32;
    localparam int unsigned BW = 4;
    localparam int unsigned CW = 4;
    localparam int unsigned MW = 8;
    localparam logic [CW-1:0] RD_LAT   = CW'(RD_LATENCY);
    localparam logic [MW-1:0] MISS_MAX = '1;

    // One-hot so every bus strobe is a single state-bit decode.
    typedef enum logic [3:0] {
        S_IDLE  = 4'b0001,
        S_ISSUE = 4'b0010,
        S_WAIT  = 4'b0100,
        S_RESP  = 4'b1000
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [BW-1:0]   be_q, be_d;
    logic            is_wr_q, is_wr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic [MW-1:0]   miss_q, miss_d;

    logic            start_c;
    logic            hit_c;
    logic            unused_addr_c;

    assign start_c       = io_addr_strobe && (io_read_strobe || io_write_strobe);
    assign hit_c         = (io_address[31:24] == BRIDGE_BASE[31:24]);
    assign unused_addr_c = ^{io_address[23], io_address[1:0]};

    // Next-state and datapath updates.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        is_wr_d = is_wr_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        miss_d  = miss_q;
        case (state_q)
            S_IDLE: begin
                if (start_c) begin
                    addr_d  = io_address[22:2];
                    wdata_d = io_write_data;
                    be_d    = io_byte_enable;
                    is_wr_d = io_write_strobe;
                    if (hit_c) begin
                        state_d = S_ISSUE;
                    end else begin
                        state_d = S_RESP;
                        rdata_d = '0;
                        if (miss_q != MISS_MAX) begin
                            miss_d = miss_q + MW'(1);
                        end
                    end
                end
            end
            S_ISSUE: begin
                if (is_wr_q) begin
                    state_d = S_RESP;
                end else if (RD_LAT == '0) begin
                    rdata_d = sys_rd_data;
                    state_d = S_RESP;
                end else begin
                    cnt_d   = RD_LAT;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // The edge that takes the counter to zero is the capture edge.
                if (cnt_q <= CW'(1)) begin
                    cnt_d   = '0;
                    rdata_d = sys_rd_data;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            is_wr_q <= 1'b0;
            cnt_q   <= '0;
            rdata_q <= '0;
            miss_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            is_wr_q <= is_wr_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            miss_q  <= miss_d;
        end
    end

    assign io_ready     = (state_q == S_RESP);
    assign sys_mmio_cs  = (state_q == S_ISSUE);
    assign sys_wr       = sys_mmio_cs && is_wr_q;
    assign sys_rd       = sys_mmio_cs && !is_wr_q;
    assign sys_addr     = addr_q;
    assign sys_wr_data  = wdata_q;
    assign sys_be       = be_q;
    assign io_read_data = rdata_q;
    assign miss_count   = miss_q;

endmodule

// File: tb/tb_io_bus_bridge_reg.sv
// Scoreboard bench for io_bus_bridge_reg: two instances (read latency 0 and 3) share stimulus;
// expected bus strobes and responses are queued at issue time and popped by a negedge monitor.
module tb_io_bus_bridge_reg;

    typedef struct {
        int          cyc;
        logic [31:0] rdata;
        logic [7:0]  mc;
    } resp_t;

    typedef struct {
        int          cyc;
        logic        wr;
        logic [20:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } sys_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        io_addr_strobe = 1'b0;
    logic        io_read_strobe = 1'b0;
    logic        io_write_strobe = 1'b0;
    logic [3:0]  io_byte_enable = '0;
    logic [31:0] io_address = '0;
    logic [31:0] io_write_data = '0;
    logic [31:0] sys_rd_data = '0;

    logic [31:0] rdat0, rdat3, wd0, wd3;
    logic        rdy0, rdy3, cs0, cs3, w0, w3, r0, r3;
    logic [20:0] a0, a3;
    logic [3:0]  be0, be3;
    logic [7:0]  mc0, mc3;

    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    bit          rd_mode = 1'b0;
    logic [31:0] rd_fixed = '0;
    logic [31:0] last_rd0 = '0;
    logic [31:0] last_rd3 = '0;
    logic [7:0]  mc_m = '0;

    resp_t rq0[$];
    resp_t rq3[$];
    sys_t  sq0[$];
    sys_t  sq3[$];

    io_bus_bridge_reg #(.BRIDGE_BASE(32'hc000_0000), .RD_LATENCY(0)) dut0 (
        .clk(clk), .reset(rst_n),
        .io_addr_strobe(io_addr_strobe), .io_read_strobe(io_read_strobe),
        .io_write_strobe(io_write_strobe), .io_byte_enable(io_byte_enable),
        .io_address(io_address), .io_write_data(io_write_data),
        .io_read_data(rdat0), .io_ready(rdy0),
        .sys_mmio_cs(cs0), .sys_wr(w0), .sys_rd(r0), .sys_addr(a0),
        .sys_wr_data(wd0), .sys_be(be0), .sys_rd_data(sys_rd_data),
        .miss_count(mc0)
    );

    io_bus_bridge_reg #(.BRIDGE_BASE(32'hc000_0000), .RD_LATENCY(3)) dut3 (
        .clk(clk), .reset(rst_n),
        .io_addr_strobe(io_addr_strobe), .io_read_strobe(io_read_strobe),
        .io_write_strobe(io_write_strobe), .io_byte_enable(io_byte_enable),
        .io_address(io_address), .io_write_data(io_write_data),
        .io_read_data(rdat3), .io_ready(rdy3),
        .sys_mmio_cs(cs3), .sys_wr(w3), .sys_rd(r3), .sys_addr(a3),
        .sys_wr_data(wd3), .sys_be(be3), .sys_rd_data(sys_rd_data),
        .miss_count(mc3)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Read data is either a fixed word or a per-cycle tag so the capture cycle is visible.
    always @(posedge clk) begin
        #1;
        sys_rd_data = rd_mode ? (32'ha500_0000 | 32'(cyc)) : rd_fixed;
    end

    task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d cyc %0d: got %h expected %h", nm, id, cyc, act, exp);
        end
    endtask

    task automatic mon(input int id, input logic rdy, input logic [31:0] rdat, input logic [7:0] mc,
                       input logic cs, input logic w, input logic r, input logic [20:0] a,
                       input logic [31:0] wd, input logic [3:0] be);
        resp_t e;
        sys_t  s;
        int    n;
        if (rdy) begin
            n = (id == 0) ? rq0.size() : rq3.size();
            if (n == 0) begin
                chk("unexpected_ready", id, 32'(rdy), 32'd0);
            end else begin
                if (id == 0) e = rq0.pop_front();
                else         e = rq3.pop_front();
                chk("ready_cycle", id, 32'(cyc), 32'(e.cyc));
                chk("io_read_data", id, rdat, e.rdata);
                chk("miss_count", id, 32'(mc), 32'(e.mc));
            end
        end
        if (w && r) chk("rd_wr_same_cycle", id, 32'(r), 32'd0);
        if (cs) begin
            n = (id == 0) ? sq0.size() : sq3.size();
            if (n == 0) begin
                chk("unexpected_sys_cs", id, 32'(cs), 32'd0);
            end else begin
                if (id == 0) s = sq0.pop_front();
                else         s = sq3.pop_front();
                chk("sys_cycle", id, 32'(cyc), 32'(s.cyc));
                chk("sys_wr", id, 32'(w), 32'(s.wr));
                chk("sys_rd", id, 32'(r), 32'(!s.wr));
                chk("sys_addr", id, 32'(a), 32'(s.addr));
                chk("sys_wr_data", id, wd, s.wdata);
                chk("sys_be", id, 32'(be), 32'(s.be));
            end
        end else if (w || r) begin
            chk("strobe_without_cs", id, 32'({w, r}), 32'd0);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            mon(0, rdy0, rdat0, mc0, cs0, w0, r0, a0, wd0, be0);
            mon(3, rdy3, rdat3, mc3, cs3, w3, r3, a3, wd3, be3);
        end
    end

    task automatic zero_chk(input int id, input logic rdy, input logic [31:0] rdat, input logic [7:0] mc,
                            input logic cs, input logic w, input logic r, input logic [20:0] a,
                            input logic [31:0] wd, input logic [3:0] be);
        chk("rst_io_ready", id, 32'(rdy), 32'd0);
        chk("rst_io_read_data", id, rdat, 32'd0);
        chk("rst_miss_count", id, 32'(mc), 32'd0);
        chk("rst_sys_strobes", id, 32'({cs, w, r}), 32'd0);
        chk("rst_sys_addr", id, 32'(a), 32'd0);
        chk("rst_sys_wr_data", id, wd, 32'd0);
        chk("rst_sys_be", id, 32'(be), 32'd0);
    endtask

    // Issue one IO transaction and queue what both instances should do in response.
    task automatic txn(input logic r, input logic w, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] be, input bit expect_resp);
        resp_t e0, e3;
        sys_t  s;
        int    c0;
        @(posedge clk);
        #1;
        io_addr_strobe  = 1'b1;
        io_read_strobe  = r;
        io_write_strobe = w;
        io_address      = a;
        io_write_data   = wd;
        io_byte_enable  = be;
        c0 = cyc;
        if (a[31:24] == 8'hc0) begin
            s.cyc = c0 + 1; s.wr = w; s.addr = a[22:2]; s.wdata = wd; s.be = be;
            sq0.push_back(s);
            sq3.push_back(s);
            if (w) begin
                e0.cyc = c0 + 2; e0.rdata = last_rd0;
                e3.cyc = c0 + 2; e3.rdata = last_rd3;
            end else begin
                e0.cyc = c0 + 2;
                e3.cyc = c0 + 5;
                e0.rdata = rd_mode ? (32'ha500_0000 | 32'(c0 + 1)) : rd_fixed;
                e3.rdata = rd_mode ? (32'ha500_0000 | 32'(c0 + 4)) : rd_fixed;
            end
        end else begin
            mc_m = (mc_m == 8'hff) ? 8'hff : mc_m + 8'd1;
            e0.cyc = c0 + 1; e0.rdata = '0;
            e3.cyc = c0 + 1; e3.rdata = '0;
        end
        e0.mc = mc_m;
        e3.mc = mc_m;
        if (expect_resp) begin
            rq0.push_back(e0);
            rq3.push_back(e3);
            last_rd0 = e0.rdata;
            last_rd3 = e3.rdata;
        end
        @(posedge clk);
        #1;
        io_addr_strobe  = 1'b0;
        io_read_strobe  = 1'b0;
        io_write_strobe = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40; i++) begin
            if (rq0.size() == 0 && rq3.size() == 0 && sq0.size() == 0 && sq3.size() == 0) break;
            @(negedge clk);
        end
        if (rq0.size() != 0 || rq3.size() != 0 || sq0.size() != 0 || sq3.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout pending resp %0d/%0d sys %0d/%0d at cyc %0d",
                     rq0.size(), rq3.size(), sq0.size(), sq3.size(), cyc);
            rq0.delete(); rq3.delete(); sq0.delete(); sq3.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout at cyc %0d", cyc);
        $fatal(1, "global timeout");
    end

    initial begin
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        zero_chk(0, rdy0, rdat0, mc0, cs0, w0, r0, a0, wd0, be0);
        zero_chk(3, rdy3, rdat3, mc3, cs3, w3, r3, a3, wd3, be3);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        txn(1'b0, 1'b1, 32'hc000_0010, 32'hdead_beef, 4'hf, 1'b1);
        wait_done();

        rd_mode  = 1'b0;
        rd_fixed = 32'h1234_5678;
        txn(1'b1, 1'b0, 32'hc000_0004, 32'h0, 4'hf, 1'b1);
        wait_done();

        rd_mode = 1'b1;
        txn(1'b1, 1'b0, 32'hc012_3458, 32'h0, 4'hf, 1'b1);
        wait_done();

        txn(1'b1, 1'b0, 32'h8000_0000, 32'h0, 4'hf, 1'b1);
        wait_done();

        txn(1'b1, 1'b1, 32'hc000_0020, 32'h5555_aaaa, 4'h3, 1'b1);
        wait_done();

        for (int i = 0; i < 300; i++) begin
            txn(1'b1, 1'b0, 32'h1000_0000 + 32'(i * 4), 32'h0, 4'hf, 1'b1);
            wait_done();
        end

        // Reset while the latency-3 instance is waiting: no completion may follow.
        txn(1'b1, 1'b0, 32'hc000_0008, 32'h0, 4'hf, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        zero_chk(3, rdy3, rdat3, mc3, cs3, w3, r3, a3, wd3, be3);
        zero_chk(0, rdy0, rdat0, mc0, cs0, w0, r0, a0, wd0, be0);
        mc_m     = '0;
        last_rd0 = '0;
        last_rd3 = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        wait_done();

        txn(1'b1, 1'b0, 32'hc000_000c, 32'h0, 4'hf, 1'b1);
        wait_done();
        txn(1'b0, 1'b1, 32'hc0ff_fffc, 32'h0bad_f00d, 4'h9, 1'b1);
        wait_done();
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
